// File: rtl/stage_ex_pkg.sv
// stage_ex_pkg: definitions shared by the multi-cycle execute stage.
//   exeCmd_e : ALU command encodings (MUL added at 4'b1010)
//   state_t  : multiply sequencer states
//   FLAG_*   : bit positions of {N,Z,C,V} inside the status word
package stage_ex_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MUL = 4'b1010
  } exeCmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/stage_ex_mc_mul_iter.sv
// mul_iter: iterative shift-add multiplier datapath, STEP multiplier bits per cycle.
//   clk        in  clock
//   load       in  capture operands, clear accumulator, load iteration count
//   iterate    in  retire STEP multiplier bits this cycle
//   mcandIn    in  multiplicand
//   mplierIn   in  multiplier
//   acc        out accumulated product (low DATA_W bits)
//   mplierZero out remaining multiplier is zero
//   lastIter   out this is the final scheduled iteration
// Registers carry no reset: a load always precedes any use.
module mul_iter
  import stage_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              load,
  input  logic              iterate,
  input  logic [DATA_W-1:0] mcandIn,
  input  logic [DATA_W-1:0] mplierIn,
  output logic [DATA_W-1:0] acc,
  output logic              mplierZero,
  output logic              lastIter
);

  localparam int ITERS = DATA_W / STEP;
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] pp;
  logic [CNT_W-1:0]  count;

  // multiplicand x low STEP multiplier bits, truncated to DATA_W
  always_comb begin
    pp = '0;
    for (int b = 0; b < STEP; b++) begin
      if (mplier[b]) pp = pp + (mcand << b);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mcand  <= mcandIn;
      mplier <= mplierIn;
      acc    <= '0;
      count  <= CNT_W'(ITERS);
    end else if (iterate) begin
      acc    <= acc + pp;
      mcand  <= mcand << STEP;
      mplier <= mplier >> STEP;
      count  <= count - CNT_W'(1);
    end
  end

  assign mplierZero = (mplier == '0);
  assign lastIter   = (count == CNT_W'(1));

endmodule

// File: rtl/stage_ex_mc.sv
// stage_ex_mc: multi-cycle execute stage (ALU, branch target, status flags,
// iterative MUL that stalls the front end through busy).
//   clk, rst (async, active-high), freeze (downstream hold)
//   wbEnIn/memREnIn/memWEnIn/branchTakenIn/ldStatus/imm/carryIn, exeCmd : decoded controls
//   val1, valRm, signedImm24, pc, shifterOperand, dest : operands
//   wbEnOut/memREnOut/memWEnOut/branchTakenOut, aluRes, exeValRm, branchAddr,
//   exeDest, status {N,Z,C,V}, busy : outputs towards EX/MEM and hazard unit
// Build option: STAGE_EX_MUL_EARLY_EXIT_EN ends a MUL once the remaining
// multiplier is zero; otherwise a MUL always runs DATA_W/STEP iterations.
module stage_ex_mc
  import stage_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wbEnIn,
  input  logic              memREnIn,
  input  logic              memWEnIn,
  input  logic              branchTakenIn,
  input  logic              ldStatus,
  input  logic              imm,
  input  logic              carryIn,
  input  logic [3:0]        exeCmd,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] valRm,
  input  logic [DATA_W-1:0] signedImm24,
  input  logic [DATA_W-1:0] pc,
  input  logic [11:0]       shifterOperand,
  input  logic [3:0]        dest,
  output logic              wbEnOut,
  output logic              memREnOut,
  output logic              memWEnOut,
  output logic              branchTakenOut,
  output logic [DATA_W-1:0] aluRes,
  output logic [DATA_W-1:0] exeValRm,
  output logic [DATA_W-1:0] branchAddr,
  output logic [3:0]        exeDest,
  output logic [3:0]        status,
  output logic              busy
);

  logic [DATA_W-1:0]        val2;
  logic signed [DATA_W-1:0] valRmS;
  logic [2*DATA_W-1:0]      rotImm;
  logic [2*DATA_W-1:0]      rotRm;
  int                       immAmt;
  int                       shAmt;

  assign valRmS = valRm;

  // Operand 2: memory ops take the raw 12-bit offset, immediates are an
  // 8-bit value rotated right by twice the 4-bit field, otherwise Rm shifted.
  always_comb begin
    immAmt = (2 * int'(shifterOperand[11:8])) % DATA_W;
    shAmt  = int'(shifterOperand[11:7]) % DATA_W;
    rotImm = {2{DATA_W'(shifterOperand[7:0])}} >> immAmt;
    rotRm  = {2{valRm}} >> shAmt;
    if (memREnIn || memWEnIn) begin
      val2 = DATA_W'(shifterOperand);
    end else if (imm) begin
      val2 = rotImm[DATA_W-1:0];
    end else begin
      case (shifterOperand[6:5])
        2'b00:   val2 = valRm << shAmt;
        2'b01:   val2 = valRm >> shAmt;
        2'b10:   val2 = valRmS >>> shAmt;
        default: val2 = rotRm[DATA_W-1:0];
      endcase
    end
  end

  logic signed [DATA_W-1:0] opA;
  logic signed [DATA_W-1:0] opB;
  logic [DATA_W:0]          sum;
  logic [DATA_W-1:0]        aluOut;
  logic                     aluC;
  logic                     aluV;
  logic [3:0]               aluFlags;

  assign opA = val1;
  assign opB = val2;

  // Logic/move ops leave C and V as they are.
  always_comb begin
    sum    = '0;
    aluOut = '0;
    aluC   = status[FLAG_C];
    aluV   = status[FLAG_V];
    case (exeCmd)
      CMD_MOV: aluOut = val2;
      CMD_MVN: aluOut = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, val1} + {1'b0, val2}
               + {{DATA_W{1'b0}}, carryIn & (exeCmd == CMD_ADC)};
        aluOut = sum[DATA_W-1:0];
        aluC   = sum[DATA_W];
        aluV   = ((opA < 0) == (opB < 0)) && (aluOut[DATA_W-1] != (opA < 0));
      end
      CMD_SUB, CMD_SBC: begin
        sum    = {1'b0, val1} - {1'b0, val2}
               - {{DATA_W{1'b0}}, ~carryIn & (exeCmd == CMD_SBC)};
        aluOut = sum[DATA_W-1:0];
        aluC   = ~sum[DATA_W];  // carry means "no borrow"
        aluV   = ((opA < 0) != (opB < 0)) && (aluOut[DATA_W-1] != (opA < 0));
      end
      CMD_AND: aluOut = val1 & val2;
      CMD_ORR: aluOut = val1 | val2;
      CMD_EOR: aluOut = val1 ^ val2;
      default: aluOut = '0;
    endcase
  end

  assign aluFlags = {aluOut[DATA_W-1], (aluOut == '0), aluC, aluV};

  state_t            state;
  logic              mulReq;
  logic              mulIterate;
  logic              runToDone;
  logic              mplierZero;
  logic              lastIter;
  logic [DATA_W-1:0] acc;
  logic              capLd;
  logic              capWb;
  logic [3:0]        capDest;

  assign mulReq = (state == ST_IDLE) && (exeCmd == CMD_MUL) && wbEnIn;

`ifdef STAGE_EX_MUL_EARLY_EXIT_EN
  // zero remaining multiplier is tested before iterating, so a x0 skips RUN work
  assign mulIterate = (state == ST_RUN) && !mplierZero;
  assign runToDone  = mplierZero || lastIter;
`else
  assign mulIterate = (state == ST_RUN);
  assign runToDone  = lastIter;
`endif

  mul_iter #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) uMulIter (
    .clk        (clk),
    .load       (mulReq),
    .iterate    (mulIterate),
    .mcandIn    (val1),
    .mplierIn   (val2),
    .acc        (acc),
    .mplierZero (mplierZero),
    .lastIter   (lastIter)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      status <= '0;
      capLd  <= 1'b0;
      capWb  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mulReq) begin
            state <= ST_RUN;
            capLd <= ldStatus;
            capWb <= wbEnIn;
          end else if (ldStatus && !freeze) begin
            status <= aluFlags;
          end
        end
        ST_RUN: begin
          if (runToDone) state <= ST_DONE;
        end
        ST_DONE: begin
          if (!freeze) begin
            state <= ST_IDLE;
            if (capLd) begin
              status[FLAG_N] <= acc[DATA_W-1];
              status[FLAG_Z] <= (acc == '0);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mulReq) capDest <= dest;
  end

  assign exeValRm   = valRm;
  assign branchAddr = pc + signedImm24;

  // Request and RUN cycles send a bubble to EX/MEM; reset forces quiet outputs.
  always_comb begin
    aluRes         = aluOut;
    wbEnOut        = wbEnIn;
    memREnOut      = memREnIn;
    memWEnOut      = memWEnIn;
    branchTakenOut = branchTakenIn;
    exeDest        = dest;
    busy           = 1'b0;
    if (rst) begin
      aluRes         = '0;
      wbEnOut        = 1'b0;
      memREnOut      = 1'b0;
      memWEnOut      = 1'b0;
      branchTakenOut = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mulReq) begin
            busy           = 1'b1;
            wbEnOut        = 1'b0;
            memREnOut      = 1'b0;
            memWEnOut      = 1'b0;
            branchTakenOut = 1'b0;
          end
        end
        ST_RUN: begin
          busy           = 1'b1;
          wbEnOut        = 1'b0;
          memREnOut      = 1'b0;
          memWEnOut      = 1'b0;
          branchTakenOut = 1'b0;
        end
        ST_DONE: begin
          aluRes    = acc;
          wbEnOut   = capWb;
          memREnOut = 1'b0;
          memWEnOut = 1'b0;
          exeDest   = capDest;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stage_ex_mc.md
# stage_ex_mc

Parametrised multi-cycle execute stage for the ARM-subset pipeline, sitting between the ID/EX and EX/MEM registers. It performs the existing single-cycle ALU operations, computes branch targets and holds the status flags. It adds an iterative shift-add `MUL` unit that stalls the front end through `busy` until the product is ready.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; multiple of `STEP`, ≥ 8.
- `STEP`, 1, multiplier bits retired per cycle; 1, 2 or 4.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `freeze`  in  1  downstream/hazard stall; ID/EX and EX/MEM hold this cycle.
- `wbEnIn`, `memREnIn`, `memWEnIn`, `branchTakenIn`, `ldStatus`, `imm`, `carryIn`  in  1 each  decoded controls.
- `exeCmd`  in  4  ALU command; `MUL` = 4'b1010.
- `val1`, `valRm`, `signedImm24`, `pc`  in  DATA_W  operands.
- `shifterOperand`  in  12  shifter field.
- `dest`  in  4  destination register.
- `wbEnOut`, `memREnOut`, `memWEnOut`, `branchTakenOut`  out  1 each  controls to EX/MEM.
- `aluRes`, `exeValRm`, `branchAddr`  out  DATA_W  results.
- `exeDest`  out  4  destination.
- `status`  out  4  registered flags {N,Z,C,V}.
- `busy`  out  1  stall request to the hazard unit.

## Operation
- `val2` is generated from `imm`, `valRm` and `shifterOperand`. Memory instructions force the 12-bit immediate offset.
- `branchAddr` = `pc` + `signedImm24`, mod 2^DATA_W, every cycle.
- Non-`MUL` commands are combinational, as before.
  - `status` loads the ALU flags on the edge where `ldStatus` & !`freeze` & state is IDLE.
- A `MUL` request is `exeCmd`==`MUL` & `wbEnIn` in state IDLE.
- FSM:
  - **IDLE**, on a request:
    - `busy`=1.
    - Capture `val1` as the multiplicand and `val2` as the multiplier.
    - Capture `dest`, `ldStatus` and `wbEnIn`.
    - Clear the accumulator, load `count`=DATA_W/STEP, then go to RUN.
    - No request: stay in IDLE.
  - **RUN**:
    - `busy`=1.
    - Each cycle: `acc` += multiplicand × (low STEP multiplier bits); multiplicand <<= STEP; multiplier >>= STEP; `count`--.
    - When `count` reaches 0, go to DONE.
  - **DONE**:
    - `busy`=0.
    - `aluRes` = `acc` (low DATA_W bits of the product).
    - Controls pass through from the inputs; `memREnOut`/`memWEnOut` are 0 for `MUL`.
    - If the captured `ldStatus` is set: N = `acc`[DATA_W-1], Z = (`acc`==0), C and V unchanged.
    - The flag update and the return to IDLE happen on the first edge with !`freeze`. While `freeze` is high, stay in DONE with outputs held.
- In IDLE-request and RUN cycles:
  - `wbEnOut`, `memREnOut`, `memWEnOut` and `branchTakenOut` are forced to 0, so EX/MEM receives a bubble.
  - `status` is not updated.
- `freeze` in RUN does not pause iteration.
- A `MUL` request is never re-accepted in DONE, so back-to-back `MUL`s restart from IDLE.

## Timing
- Non-`MUL` commands: 0-cycle latency; `busy`=0.
- `MUL`, without early exit:
  - Request at cycle 0.
  - `busy` high for cycles 0..N, where N = DATA_W/STEP.
  - Result valid in cycle N+1.
  - DATA_W=32, STEP=1: 33 stall cycles.
- `busy` is combinational from state and the request, so the hazard unit sees it in the request cycle.
- Reset, asserted at any time including mid-`MUL`:
  - State goes to IDLE; `status` is cleared to 0.
  - `busy`, `wbEnOut`, `memREnOut`, `memWEnOut` and `branchTakenOut` are 0 while `rst` is high.
  - `aluRes` = 0 while `rst` is high.
  - The partial product is discarded.

## Configuration
- `STAGE_EX_MUL_EARLY_EXIT_EN` defined:
  - RUN goes to DONE as soon as the remaining multiplier is 0, checked before each iteration.
  - Multiply by 0 gives `busy` in cycles 0–1 and the result in cycle 2.
- Undefined: fixed N iterations regardless of operands.
- The result is identical either way.

## Structure
- Shared package `stage_ex_pkg`:
  - `exeCmd` encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, MUL).
  - FSM state encoding IDLE/RUN/DONE.
  - Flag bit indices.
- One sub-module, `mul_iter`, owns the multiplicand, multiplier, accumulator and count registers and the STEP-bit partial-product adder.
- The FSM, val2 generation, ALU and status register stay in `stage_ex_mc`.

## Test plan
- ADD 5 + 7 with `ldStatus`=1 → `aluRes`=12, `busy`=0, `status`=0000 after the edge; CMP 3,3 → Z=1, C=1.
- MUL 0x0000_1234 × 0x0000_0010, DATA_W=32, STEP=1 → `busy` high 33 cycles, `wbEnOut`=0 throughout, then `aluRes`=0x0001_2340 for one cycle.
- MUL 0xFFFF_FFFF × 2 with `ldStatus`=1 and C=V=1 beforehand → `aluRes`=0xFFFF_FFFE, `status`=N1 Z0 C1 V1.
- MUL by 0 → 33 stall cycles without the macro, 2 with it; `aluRes`=0 and Z=1 in both.
- `rst` pulsed at cycle 10 of a MUL → `busy` drops immediately, `status`=0; the next ADD completes single-cycle.
- `freeze` held 3 cycles while in DONE → `aluRes` and `wbEnOut`=1 stable, `status` updates once on release; STEP=4 MUL takes 9 stall cycles.
